// File: rtl/player_hit_if.sv
// Bundle between the frame/collision logic and the player hit controller.
// frame_tick and restart are single-cycle pulses and is_trigger_player is a level; all are sampled on clk.
interface player_hit_if;
  logic       frame_tick;
  logic       is_trigger_player;
  logic       restart;
  logic [6:0] hp;
  logic       hp_dec_pulse;
  logic       player_visible;
  logic       flash_active;
  logic       invuln;
  logic       game_over;
  logic [1:0] state_dbg;

  modport master (
    output frame_tick,
    output is_trigger_player,
    output restart,
    input  hp,
    input  hp_dec_pulse,
    input  player_visible,
    input  flash_active,
    input  invuln,
    input  game_over,
    input  state_dbg
  );

  modport slave (
    input  frame_tick,
    input  is_trigger_player,
    input  restart,
    output hp,
    output hp_dec_pulse,
    output player_visible,
    output flash_active,
    output invuln,
    output game_over,
    output state_dbg
  );
endinterface

// File: rtl/player_hit_controller.sv
// Frame-synchronous player hit controller: HP, invulnerability window, blink and damage flash.
// Every state change lands on frame_tick so renderer-facing outputs are stable across a frame.
module player_hit_controller #(
  parameter int HP_MAX        = 92,
  parameter int DAMAGE        = 1,
  parameter int INVULN_FRAMES = 30,
  parameter int BLINK_PERIOD  = 4,
  parameter int FLASH_FRAMES  = 2
) (
  input logic         clk,
  input logic         reset,
  player_hit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  localparam logic [6:0] HP_INIT    = 7'(HP_MAX);
  localparam logic [6:0] DMG        = 7'(DAMAGE);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_LOAD = 8'(BLINK_PERIOD - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  state_e     state_q, state_d;
  logic [6:0] hp_q, hp_d;
  logic       hit_pending_q, hit_pending_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       visible_q, visible_d;
  logic       pulse_q, pulse_d;
  logic       flash_active_q, flash_active_d;

  logic       frame_hit;
  logic [6:0] hp_after_hit;

  // A hit seen anywhere in the frame, or only on the tick cycle itself, counts once.
  assign frame_hit    = hit_pending_q | (bus.is_trigger_player & bus.frame_tick);
  assign hp_after_hit = (hp_q > DMG) ? (hp_q - DMG) : 7'd0;

  always_comb begin
    state_d       = state_q;
    hp_d          = hp_q;
    hit_pending_d = hit_pending_q;
    inv_cnt_d     = inv_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    visible_d     = visible_q;
    pulse_d       = 1'b0;

    if (bus.restart) begin
      state_d       = ST_ALIVE;
      hp_d          = HP_INIT;
      hit_pending_d = 1'b0;
      inv_cnt_d     = 8'd0;
      blink_cnt_d   = 8'd0;
      flash_cnt_d   = 8'd0;
      visible_d     = 1'b1;
    end else begin
      if (bus.frame_tick && (flash_cnt_q != 8'd0)) begin
        flash_cnt_d = flash_cnt_q - 8'd1;
      end

      if (bus.frame_tick) begin
        hit_pending_d = 1'b0;
      end else if ((state_q == ST_ALIVE) && bus.is_trigger_player) begin
        hit_pending_d = 1'b1;
      end

      case (state_q)
        ST_ALIVE: begin
          if (bus.frame_tick && frame_hit) begin
            hp_d        = hp_after_hit;
            pulse_d     = 1'b1;
            flash_cnt_d = FLASH_LOAD;
            visible_d   = 1'b0;
            if (hp_after_hit == 7'd0) begin
              state_d = ST_DEAD;
            end else begin
              state_d     = ST_INVULN;
              inv_cnt_d   = INV_LOAD;
              blink_cnt_d = BLINK_LOAD;
            end
          end
        end

        ST_INVULN: begin
          if (bus.frame_tick) begin
            if (inv_cnt_q == 8'd0) begin
              state_d   = ST_ALIVE;
              visible_d = 1'b1;
            end else begin
              inv_cnt_d = inv_cnt_q - 8'd1;
              if (blink_cnt_q == 8'd0) begin
                visible_d   = ~visible_q;
                blink_cnt_d = BLINK_LOAD;
              end else begin
                blink_cnt_d = blink_cnt_q - 8'd1;
              end
            end
          end
        end

        ST_DEAD: begin
          visible_d = 1'b0;
        end

        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end

    flash_active_d = (flash_cnt_d != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_ALIVE;
      hp_q           <= HP_INIT;
      hit_pending_q  <= 1'b0;
      inv_cnt_q      <= 8'd0;
      blink_cnt_q    <= 8'd0;
      flash_cnt_q    <= 8'd0;
      visible_q      <= 1'b1;
      pulse_q        <= 1'b0;
      flash_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hp_q           <= hp_d;
      hit_pending_q  <= hit_pending_d;
      inv_cnt_q      <= inv_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      flash_cnt_q    <= flash_cnt_d;
      visible_q      <= visible_d;
      pulse_q        <= pulse_d;
      flash_active_q <= flash_active_d;
    end
  end

  assign bus.hp             = hp_q;
  assign bus.hp_dec_pulse   = pulse_q;
  assign bus.player_visible = visible_q;
  assign bus.flash_active   = flash_active_q;
  assign bus.invuln         = (state_q == ST_INVULN);
  assign bus.game_over      = (state_q == ST_DEAD);
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_player_hit_controller.sv
// Bench for player_hit_controller: default instance (a) and a fatal-hit instance (b, HP_MAX=3, DAMAGE=5)
// driven in lockstep and compared against a frame-level reference model.
module tb_player_hit_controller;

  localparam int INV_F   = 30;
  localparam int BLINK_P = 4;
  localparam int FLASH_F = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_hit_if if_a ();
  player_hit_if if_b ();

  player_hit_controller dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  player_hit_controller #(
    .HP_MAX (3),
    .DAMAGE (5)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: mode 0=alive 1=invulnerable 2=dead; since = frame ticks since last accepted hit
  int p_hp_max [2] = '{92, 3};
  int p_dmg    [2] = '{1, 5};
  int m_hp     [2];
  int m_mode   [2];
  int m_since  [2];
  bit m_pend   [2];
  bit m_pulse  [2];

  task automatic model_step(input bit tk, input bit trg, input bit rs, input bit rn);
    for (int i = 0; i < 2; i++) begin
      if (!rn || rs) begin
        m_hp[i]    = p_hp_max[i];
        m_mode[i]  = 0;
        m_since[i] = 1000;
        m_pend[i]  = 1'b0;
        m_pulse[i] = 1'b0;
      end else begin
        m_pulse[i] = 1'b0;
        if (tk) begin
          if (m_mode[i] == 0 && (m_pend[i] || trg)) begin
            m_hp[i]    = (m_hp[i] > p_dmg[i]) ? m_hp[i] - p_dmg[i] : 0;
            m_pulse[i] = 1'b1;
            m_since[i] = 0;
            m_mode[i]  = (m_hp[i] == 0) ? 2 : 1;
          end else begin
            if (m_since[i] < 1000) m_since[i] = m_since[i] + 1;
            if (m_mode[i] == 1 && m_since[i] == INV_F) m_mode[i] = 0;
          end
          m_pend[i] = 1'b0;
        end else if (m_mode[i] == 0 && trg) begin
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic int exp_visible(input int i);
    if (m_mode[i] == 0) return 1;
    if (m_mode[i] == 2) return 0;
    return ((m_since[i] / BLINK_P) % 2 == 1) ? 1 : 0;
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input string n, input logic [6:0] hp, input logic pulse,
                            input logic vis, input logic fl, input logic inv, input logic go);
    check({n, "_hp"},      32'(hp),    32'(m_hp[i]));
    check({n, "_pulse"},   32'(pulse), 32'(m_pulse[i]));
    check({n, "_visible"}, 32'(vis),   32'(exp_visible(i)));
    check({n, "_flash"},   32'(fl),    32'((m_since[i] < FLASH_F) ? 1 : 0));
    check({n, "_invuln"},  32'(inv),   32'((m_mode[i] == 1) ? 1 : 0));
    check({n, "_gameover"}, 32'(go),   32'((m_mode[i] == 2) ? 1 : 0));
  endtask

  // driver
  task automatic step(input bit tk, input bit trg, input bit rs, input bit rn);
    @(negedge clk);
    if_a.frame_tick = tk;  if_b.frame_tick = tk;
    if_a.is_trigger_player = trg;  if_b.is_trigger_player = trg;
    if_a.restart = rs;  if_b.restart = rs;
    reset = rn;
    @(posedge clk);
    model_step(tk, trg, rs, rn);
    #1;
    check_inst(0, "a", if_a.hp, if_a.hp_dec_pulse, if_a.player_visible, if_a.flash_active, if_a.invuln, if_a.game_over);
    check_inst(1, "b", if_b.hp, if_b.hp_dec_pulse, if_b.player_visible, if_b.flash_active, if_b.invuln, if_b.game_over);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // len-1 body cycles with constant overlap level, then the tick cycle
  task automatic frame(input int len, input bit trg_body, input bit trg_tick);
    for (int k = 0; k < len - 1; k++) step(1'b0, trg_body, 1'b0, 1'b1);
    step(1'b1, trg_tick, 1'b0, 1'b1);
  endtask

  initial begin
    if_a.frame_tick = 1'b0;  if_b.frame_tick = 1'b0;
    if_a.is_trigger_player = 1'b0;  if_b.is_trigger_player = 1'b0;
    if_a.restart = 1'b0;  if_b.restart = 1'b0;
    reset = 1'b0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_hp_a", 32'(if_a.hp), 32'd92);
    check("reset_hp_b", 32'(if_b.hp), 32'd3);

    // single hit: 10 overlap cycles mid-frame, then the tick
    idle(5);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("hit_hp_a", 32'(if_a.hp), 32'd91);
    check("hit_pulse_a", 32'(if_a.hp_dec_pulse), 32'd1);
    check("hit_invuln_a", 32'(if_a.invuln), 32'd1);
    check("hit_visible_a", 32'(if_a.player_visible), 32'd0);
    check("fatal_hp_b", 32'(if_b.hp), 32'd0);
    check("fatal_gameover_b", 32'(if_b.game_over), 32'd1);

    // sticky overlap across three long frames, then keep overlapping until INVULN expires
    for (int f = 0; f < 3; f++) frame(167, 1'b1, 1'b1);
    check("sticky_hp_a", 32'(if_a.hp), 32'd91);
    for (int f = 3; f < INV_F - 1; f++) frame(5, 1'b1, 1'b1);
    check("before_expiry_invuln_a", 32'(if_a.invuln), 32'd1);
    frame(5, 1'b1, 1'b1);
    check("expiry_invuln_a", 32'(if_a.invuln), 32'd0);
    check("expiry_hp_a", 32'(if_a.hp), 32'd91);
    check("dead_hp_b", 32'(if_b.hp), 32'd0);

    // overlap now counts again: second hit, then restart mid-INVULN (and in DEAD for b)
    frame(4, 1'b1, 1'b0);
    check("second_hit_hp_a", 32'(if_a.hp), 32'd90);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("restart_hp_a", 32'(if_a.hp), 32'd92);
    check("restart_flash_a", 32'(if_a.flash_active), 32'd0);
    check("restart_gameover_b", 32'(if_b.game_over), 32'd0);

    // restart coincident with tick and a pending hit
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("restart_tick_hp_a", 32'(if_a.hp), 32'd92);
    check("restart_tick_pulse_a", 32'(if_a.hp_dec_pulse), 32'd0);

    // overlap only on the tick cycle
    frame(6, 1'b0, 1'b0);
    frame(6, 1'b0, 1'b1);
    check("coincident_hp_a", 32'(if_a.hp), 32'd91);

    // reset mid-INVULN / mid-flash
    frame(3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("midinv_reset_hp_a", 32'(if_a.hp), 32'd92);
    check("midinv_reset_visible_a", 32'(if_a.player_visible), 32'd1);
    check("midinv_reset_invuln_a", 32'(if_a.invuln), 32'd0);

    // randomized frames, including back-to-back ticks, restarts and resets
    for (int f = 0; f < 120; f++) begin
      int len;
      int pct;
      len = $urandom_range(1, 12);
      pct = $urandom_range(0, 30);
      for (int k = 0; k < len - 1; k++) begin
        step(1'b0, ($urandom_range(0, 99) < pct), ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 299) != 0));
      end
      step(1'b1, ($urandom_range(0, 99) < pct), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 99) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
